// File: rtl/regfile_wb_commit_pkg.sv
// Shared constants and types for the writeback-commit register file.
package regfile_pkg;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NREGS    = 2 ** ADDR_W;
    localparam int unsigned ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wb_commit_if.sv
// Writeback, stall and read-port bundle between the pipeline and the register file.
interface regfile_wb_commit_if #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) ();
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              stall_i;
    logic [ADDR_W-1:0] rd_addr_a_i;
    logic [ADDR_W-1:0] rd_addr_b_i;
    logic [DATA_W-1:0] rd_data_a_o;
    logic [DATA_W-1:0] rd_data_b_o;
    logic              wb_pend_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, stall_i, rd_addr_a_i, rd_addr_b_i,
        input  rd_data_a_o, rd_data_b_o, wb_pend_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, stall_i, rd_addr_a_i, rd_addr_b_i,
        output rd_data_a_o, rd_data_b_o, wb_pend_o
    );
endinterface

// File: rtl/regfile_wb_commit_decode.sv
// Address-to-one-hot write-enable decoder; all outputs low when disabled.
module wr_onehot_decode #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NOUT   = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [NOUT-1:0]   onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/regfile_wb_commit.sv
// Register file with a one-cycle writeback commit register, one-hot array
// write enables, and two read ports that bypass the pending write.
module regfile_wb_commit
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
    input logic                clk_i,
    input logic                reset_ni,
    regfile_wb_commit_if.slave bus
);
    localparam int unsigned       NREGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic [NREGS-1:0]  we_dec;
    logic [NREGS-1:0]  we_onehot;
    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else if (!bus.stall_i) begin
            pend_valid <= bus.wr_en_i;
            pend_addr  <= bus.wr_addr_i;
            pend_data  <= bus.wr_data_i;
        end
    end

    wr_onehot_decode #(
        .ADDR_W (ADDR_W),
        .NOUT   (NREGS)
    ) u_we_decode (
        .addr   (pend_addr),
        .en     (pend_valid & ~bus.stall_i),
        .onehot (we_dec)
    );

    // The zero register has no storage path: its enable is cut after decode.
    always_comb begin
        we_onehot           = we_dec;
        we_onehot[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (we_onehot[i]) mem[i] <= pend_data;
            end
        end
    end

    // Zero register wins over the bypass so a pending XZR write never leaks.
    assign bus.rd_data_a_o = (bus.rd_addr_a_i == ZERO_ADDR)                  ? '0        :
                             (pend_valid && pend_addr == bus.rd_addr_a_i)    ? pend_data :
                                                                               mem[bus.rd_addr_a_i];
    assign bus.rd_data_b_o = (bus.rd_addr_b_i == ZERO_ADDR)                  ? '0        :
                             (pend_valid && pend_addr == bus.rd_addr_b_i)    ? pend_data :
                                                                               mem[bus.rd_addr_b_i];
    assign bus.wb_pend_o   = pend_valid;
endmodule

// File: tb/tb_regfile_wb_commit.sv
// Scoreboard bench for regfile_wb_commit against an architectural register model.
module tb_regfile_wb_commit;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_wb_commit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_commit #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    typedef struct {
        reg_addr_t ra;
        reg_addr_t rb;
        reg_data_t ea;
        reg_data_t eb;
        logic      ep;
    } exp_t;

    exp_t sb[$];

    // Architectural view: an accepted write is visible from the next cycle on.
    reg_data_t   arch [NREGS];
    logic        pend_model;
    bit          rst_prev;
    bit          st_prev;
    bit          we_prev;
    int unsigned wa_prev;
    reg_data_t   wd_prev;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void clear_model();
        for (int i = 0; i < NREGS; i++) arch[i] = '0;
        pend_model = 1'b0;
    endfunction

    function automatic reg_data_t model_read(input int unsigned a);
        return (a == ZERO_REG) ? '0 : arch[a];
    endfunction

    task automatic step(input bit rst, input bit we, input int unsigned wa, input reg_data_t wd,
                        input bit st, input int unsigned ra, input int unsigned rb);
        exp_t e;
        @(negedge clk);
        if (rst_prev) begin
            clear_model();
        end else if (!st_prev) begin
            if (we_prev && wa_prev != ZERO_REG) arch[wa_prev] = wd_prev;
            pend_model = we_prev;
        end
        bus.wr_en_i     = we;
        bus.wr_addr_i   = reg_addr_t'(wa);
        bus.wr_data_i   = wd;
        bus.stall_i     = st;
        bus.rd_addr_a_i = reg_addr_t'(ra);
        bus.rd_addr_b_i = reg_addr_t'(rb);
        we_prev = we; wa_prev = wa; wd_prev = wd; st_prev = st;
        #1;
        reset_n  = !rst;
        if (rst) clear_model();
        rst_prev = rst;
        e.ra = reg_addr_t'(ra);
        e.rb = reg_addr_t'(rb);
        e.ea = model_read(ra);
        e.eb = model_read(rb);
        e.ep = pend_model;
        sb.push_back(e);
    endtask

    function automatic int unsigned pick_addr();
        if ($urandom_range(0, 7) == 0) return ZERO_REG;
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, NREGS - 1);
        return $urandom_range(0, 7);
    endfunction

    // Monitor: compares the oldest expectation against the outputs late in the low phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.rd_data_a_o !== e.ea) begin
                    miscompares++;
                    $display("FAIL rd_a addr=%0d got=%h exp=%h t=%0t", e.ra, bus.rd_data_a_o, e.ea, $time);
                end
                if (bus.rd_data_b_o !== e.eb) begin
                    miscompares++;
                    $display("FAIL rd_b addr=%0d got=%h exp=%h t=%0t", e.rb, bus.rd_data_b_o, e.eb, $time);
                end
                if (bus.wb_pend_o !== e.ep) begin
                    miscompares++;
                    $display("FAIL wb_pend got=%b exp=%b t=%0t", bus.wb_pend_o, e.ep, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        rst_prev = 1'b1;
        st_prev  = 1'b0;
        we_prev  = 1'b0;
        wa_prev  = 0;
        wd_prev  = '0;
        clear_model();
        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.stall_i = 1'b0; bus.rd_addr_a_i = '0; bus.rd_addr_b_i = '0;

        // Reset held with a write presented: it must be dropped.
        step(1, 1, 3, 64'hAAAA, 0, 3, 3);
        step(1, 1, 3, 64'hAAAA, 0, 3, 0);
        step(0, 0, 0, '0, 0, 3, 3);
        step(0, 0, 0, '0, 0, 3, 3);

        // Basic write, bypass, then array.
        step(0, 1, 5, 64'h1234, 0, 5, 5);
        step(0, 0, 0, '0, 0, 5, 5);
        step(0, 0, 0, '0, 0, 5, 31);

        // Zero register write.
        step(0, 1, 31, 64'hFFFF, 0, 31, 31);
        step(0, 0, 0, '0, 0, 31, 5);
        step(0, 0, 0, '0, 0, 31, 31);

        // Back-to-back same register.
        step(0, 1, 7, 64'h1, 0, 7, 7);
        step(0, 1, 7, 64'h2, 0, 7, 7);
        step(0, 0, 0, '0, 0, 7, 7);
        step(0, 0, 0, '0, 0, 7, 5);

        // Stall holds the pending X9 write and drops X10.
        step(0, 1, 9, 64'h55, 0, 9, 10);
        for (int i = 0; i < 3; i++) step(0, 1, 10, 64'h66, 1, 9, 10);
        step(0, 0, 0, '0, 0, 9, 10);
        step(0, 0, 0, '0, 0, 9, 10);

        // Async reset while X12 is pending.
        step(0, 1, 12, 64'h77, 0, 12, 9);
        step(0, 0, 0, '0, 0, 12, 12);
        step(1, 0, 0, '0, 0, 12, 9);
        step(0, 0, 0, '0, 0, 12, 9);
        step(0, 0, 0, '0, 0, 12, 12);

        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 pick_addr(),
                 {$urandom, $urandom},
                 $urandom_range(0, 4) == 0,
                 pick_addr(),
                 pick_addr());
        end
        step(0, 0, 0, '0, 0, 0, 1);

        #10;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
